// File: rtl/dlfloat16_addsub_arbiter_if.sv
// Bundle between NUM_REQ requesters, one shared dlfloat16 add/sub unit and the arbiter.
// The arbiter takes the slave side. The requesters and the unit take the master side.
interface dlfloat16_addsub_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic                    en;
    logic [NUM_REQ-1:0]      req_valid;
    logic [16*NUM_REQ-1:0]   req_a;
    logic [16*NUM_REQ-1:0]   req_b;
    logic [NUM_REQ-1:0]      req_op;
    logic [NUM_REQ-1:0]      req_ready;
    logic [15:0]             au_a;
    logic [15:0]             au_b;
    logic                    au_op;
    logic [19:0]             au_c;
    logic [4:0]              au_exc;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [20*NUM_REQ-1:0]   rsp_c;
    logic [5*NUM_REQ-1:0]    rsp_exc;
    logic [NUM_REQ-1:0]      rsp_ready;
    logic [4:0]              exc_sticky;
    logic                    exc_clr;
    logic                    busy;

    modport master (
        output en, req_valid, req_a, req_b, req_op, au_c, au_exc, rsp_ready, exc_clr,
        input  req_ready, au_a, au_b, au_op, rsp_valid, rsp_c, rsp_exc, exc_sticky, busy
    );

    modport slave (
        input  en, req_valid, req_a, req_b, req_op, au_c, au_exc, rsp_ready, exc_clr,
        output req_ready, au_a, au_b, au_op, rsp_valid, rsp_c, rsp_exc, exc_sticky, busy
    );
endinterface

// File: rtl/dlfloat16_addsub_arbiter.sv
// Round-robin sharing of one dlfloat16 add/sub unit among NUM_REQ requesters.
// Pipeline: ISS (operands) -> unit register -> WB -> per-requester result slot.
module dlfloat16_addsub_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dlfloat16_addsub_arbiter_if.slave bus
);

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic               iss_vld_q;
    logic [ID_W-1:0]    iss_id_q, iss_id_d;
    logic               wb_vld_q;
    logic [ID_W-1:0]    wb_id_q;
    logic [15:0]        au_a_q, au_a_d;
    logic [15:0]        au_b_q, au_b_d;
    logic               au_op_q, au_op_d;
    logic [4:0]         exc_sticky_q, exc_sticky_d;

    logic               rsp_valid_q [NUM_REQ];
    logic [19:0]        rsp_c_q     [NUM_REQ];
    logic [4:0]         rsp_exc_q   [NUM_REQ];
    logic [NUM_REQ-1:0] rsp_valid_w;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic               grant_found;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    cand_id;
    logic               transfer;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            // One outstanding op per requester: blocked while in ISS, WB or holding a result.
            assign eligible[gi] = bus.req_valid[gi]
                                & ~rsp_valid_q[gi]
                                & ~(iss_vld_q && (iss_id_q == ID_W'(gi)))
                                & ~(wb_vld_q  && (wb_id_q  == ID_W'(gi)));
            assign grant[gi]    = transfer && (grant_id == ID_W'(gi));

            assign rsp_valid_w[gi]          = rsp_valid_q[gi];
            assign bus.rsp_c[20*gi +: 20]   = rsp_c_q[gi];
            assign bus.rsp_exc[5*gi +: 5]   = rsp_exc_q[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rsp_valid_q[gi] <= 1'b0;
                    rsp_c_q[gi]     <= '0;
                    rsp_exc_q[gi]   <= '0;
                end else if (wb_vld_q && (wb_id_q == ID_W'(gi))) begin
                    rsp_valid_q[gi] <= 1'b1;
                    rsp_c_q[gi]     <= bus.au_c;
                    rsp_exc_q[gi]   <= bus.au_exc;
                end else if (rsp_valid_q[gi] && bus.rsp_ready[gi]) begin
                    rsp_valid_q[gi] <= 1'b0;
                    rsp_c_q[gi]     <= '0;
                    rsp_exc_q[gi]   <= '0;
                end
            end
        end
    endgenerate

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand_id     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_id = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && eligible[cand_id]) begin
                grant_found = 1'b1;
                grant_id    = cand_id;
            end
        end
    end

    assign transfer = rst_n & bus.en & grant_found;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        iss_id_d = iss_id_q;
        au_a_d   = au_a_q;
        au_b_d   = au_b_q;
        au_op_d  = au_op_q;
        if (transfer) begin
            rr_ptr_d = grant_id;
            iss_id_d = grant_id;
            au_a_d   = bus.req_a[16*grant_id +: 16];
            au_b_d   = bus.req_b[16*grant_id +: 16];
            au_op_d  = bus.req_op[grant_id];
        end
    end

    // A clear and a new flag in the same cycle leaves only the new flag.
    assign exc_sticky_d = (bus.exc_clr ? 5'b0 : exc_sticky_q)
                        | (wb_vld_q ? bus.au_exc : 5'b0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= ID_W'(NUM_REQ - 1);
            iss_vld_q    <= 1'b0;
            iss_id_q     <= '0;
            wb_vld_q     <= 1'b0;
            wb_id_q      <= '0;
            au_a_q       <= '0;
            au_b_q       <= '0;
            au_op_q      <= 1'b0;
            exc_sticky_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            iss_vld_q    <= transfer;
            iss_id_q     <= iss_id_d;
            wb_vld_q     <= iss_vld_q;
            wb_id_q      <= iss_id_q;
            au_a_q       <= au_a_d;
            au_b_q       <= au_b_d;
            au_op_q      <= au_op_d;
            exc_sticky_q <= exc_sticky_d;
        end
    end

    assign bus.req_ready  = grant;
    assign bus.au_a       = au_a_q;
    assign bus.au_b       = au_b_q;
    assign bus.au_op      = au_op_q;
    assign bus.rsp_valid  = rsp_valid_w;
    assign bus.exc_sticky = exc_sticky_q;
    assign bus.busy       = iss_vld_q | wb_vld_q | (|rsp_valid_w);

endmodule

// File: tb/tb_dlfloat16_addsub_arbiter.sv
// Bench for dlfloat16_addsub_arbiter: behavioural stand-in for the shared unit plus
// a response scoreboard, with one task per scenario.
module tb_dlfloat16_addsub_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    initial forever #5 clk = ~clk;

    dlfloat16_addsub_arbiter_if #(.NUM_REQ(N)) bus ();

    dlfloat16_addsub_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    typedef struct {
        int          id;
        logic [19:0] c;
        logic [4:0]  exc;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    // Stand-in for the shared unit: any deterministic function of the operands will do.
    function automatic logic [19:0] unit_c(logic [15:0] a, logic [15:0] b, logic op);
        logic [15:0] s;
        s = op ? (a - b) : (a + b);
        return {op, a[2:0] ^ b[2:0], s};
    endfunction

    function automatic logic [4:0] unit_exc(logic [15:0] a, logic [15:0] b);
        return a[4:0] ^ b[4:0];
    endfunction

    always @(posedge clk) begin
        bus.au_c   <= unit_c(bus.au_a, bus.au_b, bus.au_op);
        bus.au_exc <= unit_exc(bus.au_a, bus.au_b);
    end

    initial forever @(posedge clk) cyc++;

    // Scoreboard: push on transfer, pop when a slot becomes valid.
    initial begin
        logic [N-1:0] prev_v;
        logic [N-1:0] new_v;
        logic [N-1:0] xfer;
        exp_t         e;
        prev_v = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                prev_v = '0;
            end else begin
                new_v = bus.rsp_valid & ~prev_v;
                for (int i = 0; i < N; i++) begin
                    if (new_v[i]) begin
                        tests_run++;
                        if (sb.size() == 0) begin
                            tests_failed++;
                            $display("FAIL sb_unexpected: rsp_valid[%0d] rose, required none pending", i);
                        end else begin
                            e = sb.pop_front();
                            $display("[TB] rsp id=%0d c=%h exc=%b cyc=%0d", i, bus.rsp_c[20*i +: 20],
                                     bus.rsp_exc[5*i +: 5], cyc);
                            if (e.id != i) begin
                                tests_failed++;
                                $display("FAIL sb_id: got %0d required %0d", i, e.id);
                            end
                            tests_run++;
                            if (bus.rsp_c[20*i +: 20] !== e.c) begin
                                tests_failed++;
                                $display("FAIL sb_c[%0d]: got %h required %h", i, bus.rsp_c[20*i +: 20], e.c);
                            end
                            tests_run++;
                            if (bus.rsp_exc[5*i +: 5] !== e.exc) begin
                                tests_failed++;
                                $display("FAIL sb_exc[%0d]: got %b required %b", i, bus.rsp_exc[5*i +: 5], e.exc);
                            end
                            tests_run++;
                            if (cyc != e.cyc + 3) begin
                                tests_failed++;
                                $display("FAIL sb_latency[%0d]: got %0d required 3", i, cyc - e.cyc);
                            end
                        end
                    end
                end
                prev_v = bus.rsp_valid;
                xfer   = bus.req_valid & bus.req_ready;
                for (int i = 0; i < N; i++) begin
                    if (xfer[i]) begin
                        e.id  = i;
                        e.c   = unit_c(bus.req_a[16*i +: 16], bus.req_b[16*i +: 16], bus.req_op[i]);
                        e.exc = unit_exc(bus.req_a[16*i +: 16], bus.req_b[16*i +: 16]);
                        e.cyc = cyc;
                        sb.push_back(e);
                        $display("[TB] grant id=%0d a=%h b=%h op=%0d cyc=%0d", i, bus.req_a[16*i +: 16],
                                 bus.req_b[16*i +: 16], bus.req_op[i], cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(int i, logic [15:0] a, logic [15:0] b, logic op);
        bus.req_a[16*i +: 16] = a;
        bus.req_b[16*i +: 16] = b;
        bus.req_op[i]         = op;
    endtask

    task automatic apply_reset();
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.busy || sb.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) begin
            tests_run++;
            tests_failed++;
            $display("FAIL wait_idle: busy=%0d pending=%0d required idle", bus.busy, sb.size());
        end
    endtask

    task automatic test_reset();
        #2;
        rst_n         = 1'b0;
        bus.req_valid = '1;
        #1;
        tests_run++;
        if (bus.req_ready !== '0) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b required 0000", bus.req_ready);
        end
        tests_run++;
        if ({bus.busy, bus.rsp_valid, bus.exc_sticky} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%b rsp_valid=%b sticky=%b required zeros",
                     bus.busy, bus.rsp_valid, bus.exc_sticky);
        end
        tests_run++;
        if ({bus.au_a, bus.au_b, bus.au_op} !== '0 || bus.rsp_c !== '0 || bus.rsp_exc !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: got au_a=%h au_b=%h au_op=%b required zeros",
                     bus.au_a, bus.au_b, bus.au_op);
        end
        tick();
        tick();
        rst_n         = 1'b1;
        bus.req_valid = 4'b1010;
        @(negedge clk);
        tests_run++;
        if (bus.req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL reset_first_grant: got %b required 0010", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        wait_idle();
    endtask

    task automatic test_single_op();
        wait_idle();
        tick();
        set_ops(0, 16'h3E00, 16'h3E00, 1'b0);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        tests_run++;
        if (bus.req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL single_grant: got %b required 0001", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        tests_run++;
        if (bus.au_a !== 16'h3E00 || bus.au_b !== 16'h3E00 || bus.au_op !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_iss: got a=%h b=%h op=%b required 3e00 3e00 0", bus.au_a, bus.au_b, bus.au_op);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (bus.rsp_valid[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_early: got rsp_valid[0]=%b required 0", bus.rsp_valid[0]);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (bus.rsp_valid[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_rsp: got rsp_valid[0]=%b required 1", bus.rsp_valid[0]);
        end
        wait_idle();
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_g;
        for (int i = 0; i < N; i++) set_ops(i, 16'h4000 + 16'(i * 16'h0123), 16'h0100 + 16'(i * 3), 1'(i % 2));
        apply_reset();
        bus.req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_g = 4'b0001 << (k % N);
            tests_run++;
            if (bus.req_ready !== exp_g) begin
                tests_failed++;
                $display("FAIL contention_grant[%0d]: got %b required %b", k, bus.req_ready, exp_g);
            end
            tick();
        end
        bus.req_valid = '0;
        wait_idle();
    endtask

    task automatic test_back_pressure();
        logic [19:0] held_c;
        logic [4:0]  held_exc;
        wait_idle();
        tick();
        bus.rsp_ready = 4'b1011;
        set_ops(2, 16'h4A37, 16'h0C15, 1'b1);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        tests_run++;
        if (bus.req_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL bp_grant: got %b required 0100", bus.req_ready);
        end
        for (int t = 1; t <= 2; t++) begin
            tick();
            @(negedge clk);
            tests_run++;
            if (bus.req_ready !== 4'b0000 || bus.rsp_valid[2] !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_inflight[%0d]: got ready=%b rsp_valid[2]=%b required 0000 0", t,
                         bus.req_ready, bus.rsp_valid[2]);
            end
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (bus.rsp_valid[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_rsp: got rsp_valid[2]=%b required 1", bus.rsp_valid[2]);
        end
        held_c   = unit_c(16'h4A37, 16'h0C15, 1'b1);
        held_exc = unit_exc(16'h4A37, 16'h0C15);
        for (int t = 0; t < 10; t++) begin
            tick();
            @(negedge clk);
            tests_run++;
            if (bus.rsp_valid[2] !== 1'b1 || bus.rsp_c[40 +: 20] !== held_c || bus.rsp_exc[10 +: 5] !== held_exc) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got v=%b c=%h exc=%b required 1 %h %b", t, bus.rsp_valid[2],
                         bus.rsp_c[40 +: 20], bus.rsp_exc[10 +: 5], held_c, held_exc);
            end
            tests_run++;
            if (bus.req_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_no_regrant[%0d]: got %b required 0000", t, bus.req_ready);
            end
        end
        tick();
        bus.rsp_ready = '1;
        @(negedge clk);
        tests_run++;
        if (bus.req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL bp_ack_cycle: got %b required 0000", bus.req_ready);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (bus.req_ready !== 4'b0100 || bus.rsp_valid[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_regrant: got ready=%b rsp_valid[2]=%b required 0100 0", bus.req_ready, bus.rsp_valid[2]);
        end
        tick();
        bus.req_valid = '0;
        wait_idle();
    endtask

    task automatic test_en_drain();
        wait_idle();
        tick();
        bus.rsp_ready = '0;
        set_ops(0, 16'h1111, 16'h0202, 1'b0);
        set_ops(1, 16'h2345, 16'h0067, 1'b1);
        bus.req_valid = 4'b0011;
        @(negedge clk);
        tests_run++;
        if (bus.req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL en_grant0: got %b required 0001", bus.req_ready);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (bus.req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL en_grant1: got %b required 0010", bus.req_ready);
        end
        tick();
        bus.en = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            tests_run++;
            if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL en_blocked[%0d]: got ready=%b busy=%b required 0000 1", t, bus.req_ready, bus.busy);
            end
            tick();
        end
        @(negedge clk);
        tests_run++;
        if (bus.rsp_valid !== 4'b0011) begin
            tests_failed++;
            $display("FAIL en_slots: got %b required 0011", bus.rsp_valid);
        end
        tick();
        bus.rsp_ready = '1;
        @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL en_busy_ack: got %b required 1", bus.busy);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0000 || bus.req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL en_drained: got busy=%b rsp_valid=%b ready=%b required 0 0000 0000",
                     bus.busy, bus.rsp_valid, bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        bus.en        = 1'b1;
    endtask

    task automatic test_sticky();
        wait_idle();
        tick();
        bus.exc_clr = 1'b1;
        tick();
        bus.exc_clr = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.exc_sticky !== 5'b0) begin
            tests_failed++;
            $display("FAIL sticky_clr: got %b required 00000", bus.exc_sticky);
        end
        tick();
        set_ops(0, 16'h7C04, 16'h7C00, 1'b0);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        tests_run++;
        if (bus.req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL sticky_grant: got %b required 0001", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        tick();
        bus.exc_clr = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.exc_sticky !== 5'b0) begin
            tests_failed++;
            $display("FAIL sticky_wb: got %b required 00000", bus.exc_sticky);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (bus.exc_sticky !== 5'b00100) begin
            tests_failed++;
            $display("FAIL sticky_set_clr: got %b required 00100", bus.exc_sticky);
        end
        tick();
        bus.exc_clr = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.exc_sticky !== 5'b0) begin
            tests_failed++;
            $display("FAIL sticky_clear_only: got %b required 00000", bus.exc_sticky);
        end
    endtask

    task automatic test_reset_midop();
        wait_idle();
        tick();
        set_ops(0, 16'h1234, 16'h0042, 1'b0);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        tests_run++;
        if (bus.req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL midop_grant: got %b required 0001", bus.req_ready);
        end
        tick();
        rst_n         = 1'b0;
        bus.req_valid = '1;
        #1;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.au_a !== 16'h0 || bus.req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midop_async: got busy=%b au_a=%h ready=%b required 0 0000 0000",
                     bus.busy, bus.au_a, bus.req_ready);
        end
        tick();
        tick();
        rst_n         = 1'b1;
        bus.req_valid = '0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            tests_run++;
            if (bus.rsp_valid !== 4'b0000) begin
                tests_failed++;
                $display("FAIL midop_no_rsp[%0d]: got %b required 0000", t, bus.rsp_valid);
            end
            tick();
        end
        bus.req_valid = '1;
        @(negedge clk);
        tests_run++;
        if (bus.req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL midop_next_grant: got %b required 0001", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        wait_idle();
    endtask

    initial begin
        bus.en        = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = '1;
        bus.exc_clr   = 1'b0;

        test_reset();
        test_single_op();
        test_contention();
        test_back_pressure();
        test_en_drain();
        test_sticky();
        test_reset_midop();

        wait_idle();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_leftover: got %0d pending required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
